// File: rtl/ppt_pulse_controller.sv
// PPT firing pulse-train engine: count pulses of programmable width/period on a
// 2^E divided time base, with progress/completion status back to the register map.
module ppt_pulse_controller #(
    parameter int PRESC_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  clk_div,
    input  logic [15:0] period,
    input  logic [15:0] width,
    input  logic [15:0] count,
    input  logic        run_ppt,
    output logic        pulse_out,
    output logic [15:0] count_done,
    output logic        done,
    output logic        busy
);

    // state  | meaning
    // S_IDLE | waiting for run_ppt; status from last run stays visible
    // S_RUN  | firing train in progress on the shadowed configuration
    // S_DONE | all periods fired; parked until run_ppt drops
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [5:0] EXP_MAX = 6'(PRESC_W);

    state_t              r_state;
    logic [PRESC_W-1:0]  r_presc;
    logic [15:0]         r_tick_cnt;
    logic [15:0]         r_period;
    logic [15:0]         r_width;
    logic [15:0]         r_count;
    logic [5:0]          r_exp;
    logic                r_pulse;
    logic [15:0]         r_count_done;
    logic                r_done;
    logic                r_busy;

    logic [5:0]          w_exp_raw;
    logic [5:0]          w_exp;
    logic [PRESC_W-1:0]  w_presc_max;
    logic                w_tick;
    logic                w_period_end;
    logic [15:0]         w_tick_next;
    logic [15:0]         w_cd_inc;
    logic                w_last;

    always_comb begin
        w_exp_raw = {1'b0, clk_div} + 6'd1;
        w_exp     = (w_exp_raw > EXP_MAX) ? EXP_MAX : w_exp_raw;
        for (int i = 0; i < PRESC_W; i++) begin
            w_presc_max[i] = (i < int'(r_exp));
        end
        w_tick       = (r_presc == w_presc_max);
        w_period_end = w_tick && (r_tick_cnt == r_period - 16'd1);
        w_tick_next  = r_tick_cnt;
        if (w_tick) begin
            w_tick_next = w_period_end ? 16'd0 : r_tick_cnt + 16'd1;
        end
        w_cd_inc = r_count_done + 16'd1;
        w_last   = w_period_end && (w_cd_inc == r_count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_tick_cnt   <= '0;
            r_period     <= 16'd1;
            r_width      <= '0;
            r_count      <= '0;
            r_exp        <= 6'd1;
            r_pulse      <= 1'b0;
            r_count_done <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    if (run_ppt) begin
                        r_period     <= (period == 16'd0) ? 16'd1 : period;
                        r_width      <= width;
                        r_count      <= count;
                        r_exp        <= w_exp;
                        r_count_done <= '0;
                        r_presc      <= '0;
                        r_tick_cnt   <= '0;
                        if (count == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_pulse <= (width != 16'd0);
                        end
                    end
                end
                S_RUN: begin
                    if (!run_ppt) begin
                        r_state <= S_IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_presc    <= w_tick ? '0 : r_presc + {{(PRESC_W-1){1'b0}}, 1'b1};
                        r_tick_cnt <= w_tick_next;
                        if (w_period_end) begin
                            r_count_done <= w_cd_inc;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pulse <= 1'b0;
                        end else begin
                            // pulse follows the tick count it will hold next cycle
                            r_pulse <= (w_tick_next < r_width);
                        end
                    end
                end
                S_DONE: begin
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    if (!run_ppt) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pulse_out  = r_pulse;
    assign count_done = r_count_done;
    assign done       = r_done;
    assign busy       = r_busy;

endmodule

// File: doc/ppt_pulse_controller.md
Name: ppt_pulse_controller

Overview:
Pulse-train engine for the PPT firing output. It consumes the configuration words from the I2C register map: clk_div, period, width, count and run_ppt. It generates count firing pulses of programmable width and period on a divided time base. It returns progress (count_done) and completion (done) to the register map's read-only status registers.

Parameters:
PRESC_W, 32, prescaler counter width; effective divider exponent is min(clk_div+1, PRESC_W).

Ports:
clk  input  1  system clock (32.768 kHz oscillator domain)
rst  input  1  synchronous reset, active-high
clk_div  input  5  time-base exponent: one tick every 2^(clk_div+1) clk cycles
period  input  16  firing period in ticks; 0 treated as 1
width  input  16  pulse high time in ticks; 0 means no pulse
count  input  16  number of periods (firings) to execute
run_ppt  input  1  level enable; high starts/continues, low aborts/re-arms
pulse_out  output  1  PPT firing drive
count_done  output  16  completed periods in current/last run
done  output  1  run completed all count periods
busy  output  1  high while in RUN state

Behaviour:
- Sync reset, active-high: state=IDLE, pulse_out=0, count_done=0, done=0, busy=0, prescaler=0, tick_cnt=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - pulse_out=0.
  - If run_ppt=1: latch period (0 becomes 1), width, count and divider exponent into shadow registers. Clear count_done and done, zero prescaler and tick_cnt.
  - If latched count=0: go to DONE (done=1 next cycle, count_done=0). Otherwise go to RUN.
- RUN:
  - busy=1.
  - Prescaler increments every clk. A tick is asserted when prescaler == 2^E-1, where E = latched min(clk_div+1, PRESC_W). The prescaler wraps to 0 on the tick.
  - pulse_out is registered as (tick_cnt < width_latched). It is high starting the first cycle in RUN when width > 0.
  - On a tick:
    - If tick_cnt == period_latched-1: tick_cnt <= 0 and count_done <= count_done+1. If count_done+1 == count_latched, go to DONE.
    - Otherwise tick_cnt <= tick_cnt+1.
  - width >= period: pulse_out stays high continuously across all periods of the run.
  - run_ppt=0 in RUN: abort. Go to IDLE next cycle; pulse_out=0 next cycle. count_done holds its value and done stays 0.
  - Input changes during RUN are ignored (shadow registers only); they take effect on the next start.
- DONE:
  - pulse_out=0, busy=0, done=1, count_done holds.
  - Remain in DONE while run_ppt=1; no auto-restart.
  - run_ppt=0: go to IDLE. done and count_done stay visible until the next start clears them.
- Consequence: the register map's default RUN=1 fires one train after reset, then waits for software to write RUN=0 then RUN=1.
- count_done never wraps: maximum is count_latched ≤ 65535.
- rst dominates every state in the same edge.

Test Plan:
- Basic train: clk_div=0 (tick every 2 clk), period=4, width=1, count=3, run_ppt=1 from reset release -> pulse_out high 2 clk then low 6 clk, repeated 3 times. count_done steps 1,2,3 at clk 8,16,24 after start; done=1 and busy=0 from clk 24; pulse_out=0 thereafter.
- Zero count: count=0, run_ppt rising -> DONE one cycle after start, done=1, count_done=0, pulse_out never high.
- Abort: period=10, width=5, count=100, clk_div=1; drop run_ppt after 3 completed periods -> pulse_out=0 next cycle, state IDLE, count_done=3, done=0. Raising run_ppt again clears count_done to 0 and restarts.
- Edge cases: width=0 -> pulse_out stays 0 but count_done still advances. width=6 with period=4, count=2 -> pulse_out high continuously for 16 clk (clk_div=0), then low. period=0, count=2 behaves as period=1.
- Re-arm and shadowing: changing period/width mid-RUN has no effect on the current train. After DONE, holding run_ppt=1 causes no restart; run_ppt 1→0→1 starts a new train with the new values.
- Reset mid-pulse: assert rst while pulse_out=1 -> next edge pulse_out=0, count_done=0, done=0, busy=0. Check clk_div=31 with PRESC_W=32: no tick within 1000 clk.
